// File: rtl/qam_word_feeder_pkg.sv
// Shared constants and types for the QAM modulator front end.
package qam_word_feeder_pkg;

    localparam int unsigned QAM_WORD_W      = 32;
    localparam int unsigned QAM_BYTE_W      = 8;
    localparam int unsigned QAM_BYTES_PER_W = QAM_WORD_W / QAM_BYTE_W;
    localparam int unsigned QAM_BCNT_W      = $clog2(QAM_BYTES_PER_W);

    // Modulation mode encodings used by the modulator top.
    typedef enum logic [1:0] {
        QAM_MODE_2  = 2'd0,
        QAM_MODE_4  = 2'd1,
        QAM_MODE_16 = 2'd2
    } qam_mode_e;

    localparam int unsigned QAM_BPS_2  = 1;
    localparam int unsigned QAM_BPS_4  = 2;
    localparam int unsigned QAM_BPS_16 = 4;

    // Bits carried per symbol for a given mode.
    function automatic logic [2:0] qam_bits_per_symbol(input qam_mode_e mode);
        case (mode)
            QAM_MODE_2:  return 3'(QAM_BPS_2);
            QAM_MODE_4:  return 3'(QAM_BPS_4);
            QAM_MODE_16: return 3'(QAM_BPS_16);
            default:     return 3'(QAM_BPS_2);
        endcase
    endfunction

endpackage

// File: rtl/qam_word_fifo.sv
// DEPTH x 32-bit word FIFO with registered storage and a combinational head read.
module qam_word_fifo
    import qam_word_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [QAM_WORD_W-1:0] push_data,
    input  logic                  pop,
    output logic [QAM_WORD_W-1:0] head,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [QAM_WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Word storage; contents are only visible through head when count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; the caller never pushes when full or pops when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head word, forced to zero while empty.
    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/qam_word_feeder.sv
// Packs a byte stream LSB-first into 32-bit words and buffers them for the modulator.
module qam_word_feeder
    import qam_word_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [QAM_BYTE_W-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  mod_ready,
    output logic [QAM_WORD_W-1:0] word_out,
    output logic                  word_valid,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  underrun
);

    logic [QAM_BCNT_W-1:0] byte_cnt;
    logic [QAM_WORD_W-1:0] pack;
    logic [QAM_WORD_W-1:0] pack_c;
    logic                  accept_c;
    logic                  push_c;
    logic                  pop_c;

    // Handshake and FIFO control, all derived from registered state and inputs.
    always_comb begin
        s_ready    = (fifo_count != CNT_W'(DEPTH));
        word_valid = (fifo_count != '0);
        accept_c   = s_valid && s_ready;
        push_c     = accept_c && ((byte_cnt == QAM_BCNT_W'(QAM_BYTES_PER_W - 1)) || s_last);
        pop_c      = mod_ready && word_valid;
    end

    // Merge the incoming byte into its lane; lanes above byte_cnt are still zero.
    always_comb begin
        pack_c = pack;
        pack_c[{byte_cnt, 3'b000} +: QAM_BYTE_W] = s_data;
    end

    // Byte packer state and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            pack     <= '0;
            underrun <= 1'b0;
        end else begin
            if (accept_c) begin
                if (push_c) begin
                    byte_cnt <= '0;
                    pack     <= '0;
                end else begin
                    byte_cnt <= byte_cnt + QAM_BCNT_W'(1);
                    pack     <= pack_c;
                end
            end
            if (mod_ready && !word_valid) begin
                underrun <= 1'b1;
            end
        end
    end

    qam_word_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (pack_c),
        .pop       (pop_c),
        .head      (word_out),
        .count     (fifo_count)
    );

endmodule
